lcd_rx_monitor: RTL and testbench

LCD_RX_MONITOR -- requirements
Module: lcd_rx_monitor

---
 rtl/lcd_rx_monitor_if.sv | 9 +
 rtl/lcd_rx_monitor.sv | 129 ++++++++++++
 tb/tb_lcd_rx_monitor.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_rx_monitor_if.sv
// rtl/lcd_rx_monitor_if.sv - HD44780-style write bus seen by the LCD receive monitor
interface lcd_rx_monitor_if;
  logic [7:0] lcd_data;
  logic       lcd_en;
  logic       lcd_rs;

  modport master (output lcd_data, output lcd_en, output lcd_rs);
  modport slave  (input  lcd_data, input  lcd_en, input  lcd_rs);
endinterface

// File: rtl/lcd_rx_monitor.sv
// rtl/lcd_rx_monitor.sv - snoops an HD44780 write bus and mirrors the 2x16 DDRAM image
module lcd_rx_monitor #(
  parameter int BUSY_CYCLES  = 1000,
  parameter int CLEAR_CYCLES = 41000
) (
  input  logic              clock,
  input  logic              reset,
  lcd_rx_monitor_if.slave   lcd,
  input  logic [4:0]        rd_addr,
  output logic [7:0]        rd_char,
  output logic [4:0]        cursor,
  output logic              busy,
  output logic              wr_pulse,
  output logic              cmd_err,
  output logic              dropped
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [7:0] BLANK = 8'h20;

  typedef enum logic [1:0] {IDLE, DECODE, FILL, WAIT} state_t;

  state_t          state_q, state_d;
  logic [9:0]      sync1, sync2;
  logic            en_prev;
  logic            en_fall;
  logic            cmd_rs;
  logic [7:0]      cmd_data;
  logic            is_clear;
  logic            inc_dir;
  logic [4:0]      fill_idx;
  logic [CW-1:0]   cnt;
  logic [7:0]      mem [32];

  // en, rs and data travel together so the edge and its payload stay aligned
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      en_prev <= 1'b0;
    end else begin
      sync1   <= {lcd.lcd_en, lcd.lcd_rs, lcd.lcd_data};
      sync2   <= sync1;
      en_prev <= sync2[9];
    end
  end

  assign en_fall  = en_prev & ~sync2[9];
  assign is_clear = ~cmd_rs && (cmd_data == 8'h01);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_fall) state_d = DECODE;
      DECODE:  state_d = is_clear ? FILL : WAIT;
      FILL:    if (fill_idx == 5'd31) state_d = WAIT;
      WAIT:    if (cnt <= CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= BLANK;
      rd_char  <= BLANK;
      cursor   <= '0;
      inc_dir  <= 1'b1;
      wr_pulse <= 1'b0;
      cmd_err  <= 1'b0;
      dropped  <= 1'b0;
      cmd_rs   <= 1'b0;
      cmd_data <= '0;
      fill_idx <= '0;
      cnt      <= '0;
    end else begin
      wr_pulse <= 1'b0;
      cmd_err  <= 1'b0;
      rd_char  <= mem[rd_addr];
      if (en_fall && state_q != IDLE) dropped <= 1'b1;

      case (state_q)
        IDLE: begin
          if (en_fall) begin
            cmd_rs   <= sync2[8];
            cmd_data <= sync2[7:0];
          end
        end
        DECODE: begin
          // the busy window is measured from this cycle, so load one less
          cnt      <= is_clear ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
          fill_idx <= '0;
          if (cmd_rs) begin
            mem[cursor] <= cmd_data;
            wr_pulse    <= 1'b1;
            cursor      <= inc_dir ? cursor + 5'd1 : cursor - 5'd1;
          end else if (cmd_data[7]) begin
            if (cmd_data[6:4] == 3'b000)      cursor <= {1'b0, cmd_data[3:0]};
            else if (cmd_data[6:4] == 3'b100) cursor <= {1'b1, cmd_data[3:0]};
            else                              cmd_err <= 1'b1;
          end else if (is_clear) begin
            cursor  <= '0;
            inc_dir <= 1'b1;
          end else if (cmd_data[7:1] == 7'b0000001) begin
            cursor <= '0;
          end else if (cmd_data[7:2] == 6'b000001) begin
            inc_dir <= cmd_data[1];
          end
        end
        FILL: begin
          mem[fill_idx] <= BLANK;
          fill_idx      <= fill_idx + 5'd1;
          cnt           <= cnt - CW'(1);
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// tb/tb_lcd_rx_monitor.sv - scoreboard bench for the LCD receive monitor
`timescale 1ns/1ps
module tb_lcd_rx_monitor;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       busy, wr_pulse, cmd_err, dropped;

  lcd_rx_monitor_if bus();

  lcd_rx_monitor #(.BUSY_CYCLES(1000), .CLEAR_CYCLES(41000)) dut (
    .clock(clock), .reset(reset), .lcd(bus), .rd_addr(rd_addr), .rd_char(rd_char),
    .cursor(cursor), .busy(busy), .wr_pulse(wr_pulse), .cmd_err(cmd_err), .dropped(dropped)
  );

  always #20 clock = ~clock;

  typedef struct { int kind; int val; } exp_t;   // kind 0 = write, 1 = addr error, 2 = read
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic rd_valid = 1'b0;
  int   busy_run = 0;
  int   last_busy = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pop_check(input string name, input int kind, input int act);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_unexpected"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check(name, act, e.val);
    end
  endtask

  always @(negedge clock) begin
    if (wr_pulse) pop_check("wr_cursor", 0, int'(cursor));
    if (cmd_err)  pop_check("err_cursor", 1, int'(cursor));
    if (rd_valid) begin
      pop_check("rd_char", 2, int'(rd_char));
      rd_valid = 1'b0;
    end
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  task automatic expect_ev(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic strobe_raw(input logic rs, input logic [7:0] d);
    @(negedge clock);
    bus.lcd_rs = rs;
    bus.lcd_data = d;
    bus.lcd_en = 1'b1;
    repeat (4) @(negedge clock);
    bus.lcd_en = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("busy_rise_timeout", int'(busy), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50000) begin
      @(negedge clock);
      n++;
    end
    check("busy_fall_timeout", int'(busy), 0);
    @(posedge clock);
  endtask

  task automatic access(input logic rs, input logic [7:0] d);
    strobe_raw(rs, d);
    wait_busy();
    wait_idle();
  endtask

  task automatic read_cell(input logic [4:0] a, input int exp);
    int n = 0;
    @(negedge clock);
    rd_addr = a;
    expect_ev(2, exp);
    @(posedge clock);
    #1 rd_valid = 1'b1;
    while (rd_valid && n < 10) begin
      @(posedge clock);
      n++;
    end
    check("rd_timeout", int'(rd_valid), 0);
  endtask

  initial begin
    bus.lcd_en = 1'b0;
    bus.lcd_rs = 1'b0;
    bus.lcd_data = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_rd_char", int'(rd_char), 32'h20);
    check("rst_cursor", int'(cursor), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_pulse", int'(wr_pulse), 0);
    check("rst_cmd_err", int'(cmd_err), 0);
    check("rst_dropped", int'(dropped), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    expect_ev(0, 1);
    access(1'b1, 8'h33);
    check("busy_len_write", last_busy, 1000);
    read_cell(5'd0, 32'h33);

    access(1'b0, 8'hCA);
    check("cursor_line2", int'(cursor), 26);
    expect_ev(0, 27);
    access(1'b1, 8'h35);
    read_cell(5'd26, 32'h35);
    access(1'b0, 8'h8A);
    check("cursor_line1", int'(cursor), 10);

    access(1'b0, 8'h05);
    access(1'b0, 8'h80);
    check("cursor_zero", int'(cursor), 0);
    expect_ev(0, 31);
    access(1'b1, 8'h41);
    expect_ev(0, 30);
    access(1'b1, 8'h42);
    read_cell(5'd0, 32'h41);
    read_cell(5'd31, 32'h42);
    access(1'b0, 8'h06);

    check("dropped_before", int'(dropped), 0);
    expect_ev(0, 31);
    strobe_raw(1'b1, 8'h44);
    repeat (200) @(negedge clock);
    strobe_raw(1'b1, 8'h55);
    wait_idle();
    check("dropped_after", int'(dropped), 1);
    check("cursor_after_drop", int'(cursor), 31);
    read_cell(5'd30, 32'h44);
    read_cell(5'd31, 32'h42);

    expect_ev(1, 31);
    access(1'b0, 8'h95);
    check("cursor_after_err", int'(cursor), 31);

    access(1'b0, 8'h04);
    access(1'b0, 8'h01);
    check("busy_len_clear", last_busy, 41000);
    check("cursor_after_clear", int'(cursor), 0);
    for (int i = 0; i < 32; i++) read_cell(5'(i), 32'h20);
    expect_ev(0, 1);
    access(1'b1, 8'h71);

    access(1'b0, 8'hC4);
    expect_ev(0, 21);
    access(1'b1, 8'h72);
    read_cell(5'd20, 32'h72);

    strobe_raw(1'b0, 8'h01);
    wait_busy();
    repeat (11) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_dropped", int'(dropped), 0);
    check("abort_cursor", int'(cursor), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("post_reset_idle", int'(busy), 0);
    read_cell(5'd20, 32'h20);
    read_cell(5'd0, 32'h20);
    expect_ev(0, 1);
    access(1'b1, 8'h61);
    check("busy_len_post_reset", last_busy, 1000);
    read_cell(5'd0, 32'h61);

    repeat (5) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
